// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and defaults for the decode-stage branch redirect sequencer.
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_IDLE    = 2'd0,
    BR_WAIT_DS = 2'd1,
    BR_REDIR   = 2'd2
  } br_state_e;

  localparam int CNT_W_DEF = 32;

  function automatic logic is_ctrl(input logic branch, input logic jump, input logic jr);
    return branch | jump | jr;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_target_calc.sv
// Combinational target select for branch/jump/jr and the link value pc+8.
module branch_redirect_ctrl_target_calc (
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_jr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm_sl2,
  input  logic [31:0] i_jtarget,
  input  logic [31:0] i_rs_val,
  output logic [31:0] o_tgt,
  output logic [31:0] o_link_data
);

  logic [31:0] w_pc_plus4;

  assign w_pc_plus4  = i_pc + 32'd4;
  assign o_link_data = i_pc + 32'd8;

  always_comb begin
    o_tgt = 32'd0;
    if (i_branch)    o_tgt = w_pc_plus4 + i_imm_sl2;
    else if (i_jump) o_tgt = i_jtarget;
    else if (i_jr)   o_tgt = i_rs_val;
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Decode-stage control-transfer sequencer: resolves branches/jumps, holds the redirect
// until the delay slot is fetched and the PC register accepts it, and counts branches.
//
// state      | meaning
// BR_IDLE    | no redirect owed; control instrs resolve here
// BR_WAIT_DS | taken, delay slot not yet fetched; ID held
// BR_REDIR   | delay slot fetched, redirect presented until PC register loads
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_link,
  input  logic             br_taken,
  input  logic             br_save,
  input  logic             hazard_stall,
  input  logic             except_flush,
  input  logic             ds_ready,
  input  logic             if_stall,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_imm_sl2,
  input  logic [31:0]      id_jtarget,
  input  logic [31:0]      id_rs_val,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             id_stall,
  output logic             link_we,
  output logic [31:0]      link_data,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_taken
);

  br_state_e        r_state, w_state_nxt;
  logic [31:0]      r_saved_tgt;
  logic [CNT_W-1:0] r_perf_branches, r_perf_taken;
  logic [31:0]      w_tgt, w_link_sum;
  logic             w_ctrl, w_resolve, w_take, w_go_now, w_save;

  branch_redirect_ctrl_target_calc u_target_calc (
    .i_branch    (id_branch),
    .i_jump      (id_jump),
    .i_jr        (id_jr),
    .i_pc        (id_pc),
    .i_imm_sl2   (id_imm_sl2),
    .i_jtarget   (id_jtarget),
    .i_rs_val    (id_rs_val),
    .o_tgt       (w_tgt),
    .o_link_data (w_link_sum)
  );

  // rst gates resolution so outputs read zero while reset is held
  assign w_ctrl    = is_ctrl(id_branch, id_jump, id_jr);
  assign w_resolve = ~rst & (r_state == BR_IDLE) & id_valid & w_ctrl & ~hazard_stall & ~except_flush;
  assign w_take    = (id_branch & br_taken) | id_jump | id_jr;
  assign w_go_now  = ds_ready & ~if_stall;
  assign w_save    = w_resolve & w_take & ~w_go_now;

  always_ff @(posedge clk) begin
    if (rst) r_state <= BR_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (except_flush) begin
      w_state_nxt = BR_IDLE;
    end else begin
      case (r_state)
        BR_IDLE:    if (w_save) w_state_nxt = ds_ready ? BR_REDIR : BR_WAIT_DS;
        BR_WAIT_DS: if (ds_ready) w_state_nxt = if_stall ? BR_REDIR : BR_IDLE;
        BR_REDIR:   if (!if_stall) w_state_nxt = BR_IDLE;
        default:    w_state_nxt = BR_IDLE;
      endcase
    end
  end

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_stall       = 1'b0;
    if (!rst) begin
      case (r_state)
        BR_IDLE: begin
          if (w_resolve & w_take & w_go_now) begin
            redirect_valid = 1'b1;
            redirect_pc    = w_tgt;
          end
        end
        BR_WAIT_DS: begin
          id_stall = 1'b1;
          if (w_go_now & ~except_flush) begin
            redirect_valid = 1'b1;
            redirect_pc    = r_saved_tgt;
          end
        end
        BR_REDIR: begin
          id_stall = id_valid & w_ctrl;
          if (!except_flush) begin
            redirect_valid = 1'b1;
            redirect_pc    = r_saved_tgt;
          end
        end
        default: ;
      endcase
    end
  end

  assign link_we   = w_resolve & (id_link | br_save);
  assign link_data = link_we ? w_link_sum : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_saved_tgt     <= 32'd0;
      r_perf_branches <= '0;
      r_perf_taken    <= '0;
    end else begin
      if (w_save) r_saved_tgt <= w_tgt;
      if (w_resolve) begin
        r_perf_branches <= r_perf_branches + CNT_W'(1);
        if (w_take) r_perf_taken <= r_perf_taken + CNT_W'(1);
      end
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_taken    = r_perf_taken;

endmodule
